// File: rtl/draw_pkg.sv
// Shared types and helpers for the line-draw pixel writer: FSM states, pixel format
// constants and the nibble-mask / colour-replication lookups.
package draw_pkg;

  localparam int unsigned DATAW = 16;
  localparam int unsigned MASKW = 4;

  localparam logic BPP4 = 1'b0;
  localparam logic BPP8 = 1'b1;

  // Leftmost-pixel masks; [3] covers data bits 15:12.
  localparam logic [MASKW-1:0] MASK_4BPP_LEFT  = 4'b1000;
  localparam logic [MASKW-1:0] MASK_8BPP_LEFT  = 4'b1100;
  localparam logic [MASKW-1:0] MASK_8BPP_RIGHT = 4'b0011;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_WRITE = 2'd2,
    ST_ACCUM = 2'd3
  } state_e;

  function automatic logic [MASKW-1:0] pix_mask(input logic bpp8, input logic [1:0] xlo);
    if (bpp8 == BPP4) return MASK_4BPP_LEFT >> xlo;
    return xlo[0] ? MASK_8BPP_RIGHT : MASK_8BPP_LEFT;
  endfunction

  function automatic logic [DATAW-1:0] pix_data(input logic bpp8, input logic [7:0] color);
    return (bpp8 == BPP8) ? {color, color} : {4{color[3:0]}};
  endfunction

endpackage

// File: rtl/draw_pixel_writer_if.sv
// VRAM write-request bus between the pixel writer (master) and the VRAM arbiter (slave).
interface draw_pixel_writer_if
  import draw_pkg::*;
#(
  parameter int unsigned ADDRW = 16
);
  logic             wr;
  logic [ADDRW-1:0] addr;
  logic [DATAW-1:0] data;
  logic [MASKW-1:0] mask;
  logic             ack;

  modport master (output wr, addr, data, mask, input ack);
  modport slave  (input wr, addr, data, mask, output ack);
endinterface

// File: rtl/draw_pixel_addr.sv
// Registered VRAM word address: base + y*stride + word offset of x, captured on load.
module draw_pixel_addr
  import draw_pkg::*;
#(
  parameter int unsigned CORDW = 10,
  parameter int unsigned ADDRW = 16
) (
  input  logic                    clk,
  input  logic                    reset_n_i,
  input  logic                    load,
  input  logic signed [CORDW-1:0] x,
  input  logic signed [CORDW-1:0] y,
  input  logic [ADDRW-1:0]        base,
  input  logic [ADDRW-1:0]        stride,
  input  logic                    bpp8,
  output logic [ADDRW-1:0]        addr
);

  logic [ADDRW-1:0] x_word;
  logic [ADDRW-1:0] y_off;

  // Only in-clip (non-negative) coordinates are ever consumed, so plain shifts suffice.
  always_comb begin
    x_word = (bpp8 == BPP8) ? ADDRW'($unsigned(x) >> 1) : ADDRW'($unsigned(x) >> 2);
    y_off  = ADDRW'($unsigned(y)) * stride;
  end

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      addr <= '0;
    end else if (load) begin
      addr <= base + y_off + x_word;
    end
  end

endmodule

// File: rtl/draw_pixel_writer.sv
// Pixel-stream consumer: clips (x,y), builds VRAM word address/mask/data and issues held
// write requests. Define PIXEL_COALESCE_EN to merge pixels of one word into a single write.
module draw_pixel_writer
  import draw_pkg::*;
#(
  parameter int unsigned CORDW = 10,
  parameter int unsigned ADDRW = 16
) (
  input  logic                    clk,
  input  logic                    reset_n_i,
  input  logic                    pixel_valid_i,
  output logic                    ready_o,
  input  logic signed [CORDW-1:0] x_i,
  input  logic signed [CORDW-1:0] y_i,
  input  logic                    flush_i,
  input  logic [ADDRW-1:0]        base_i,
  input  logic [ADDRW-1:0]        stride_i,
  input  logic [CORDW-1:0]        width_i,
  input  logic [CORDW-1:0]        height_i,
  input  logic                    bpp8_i,
  input  logic [7:0]              color_i,
  draw_pixel_writer_if.master     vram,
  output logic                    busy_o
);

  state_e           state_q, state_d;
  logic             ready_q;
  logic             accept, in_clip, load;
  logic             bpp8_q;
  logic [7:0]       color_q;
  logic [1:0]       xlo_q;
  logic [ADDRW-1:0] calc_addr;
  logic [ADDRW-1:0] addr_d;
  logic [DATAW-1:0] data_d;
  logic [MASKW-1:0] mask_d;

  assign accept  = pixel_valid_i && ready_o;
  assign load    = (state_q == ST_IDLE) && accept;
  assign in_clip = !x_i[CORDW-1] && !y_i[CORDW-1] &&
                   ($unsigned(x_i) < width_i) && ($unsigned(y_i) < height_i);

`ifdef PIXEL_COALESCE_EN
  logic signed [CORDW-1:0] xw_q, yw_q, xw_in, xw_cur;
  logic                    match;

  // Word column of the live coordinate: at accept with the live format, in ACCUM with the held one.
  assign xw_in  = (bpp8_i == BPP8) ? (x_i >>> 1) : (x_i >>> 2);
  assign xw_cur = (bpp8_q == BPP8) ? (x_i >>> 1) : (x_i >>> 2);
  assign match  = (state_q == ST_ACCUM) && (y_i == yw_q) && (xw_cur == xw_q);
  // Flush wins over a same-cycle pixel, so the handshake closes while it is high.
  assign ready_o = ready_q || (match && !flush_i);
`else
  logic unused_flush;
  assign unused_flush = flush_i;
  assign ready_o      = ready_q;
`endif

  draw_pixel_addr #(
    .CORDW (CORDW),
    .ADDRW (ADDRW)
  ) u_addr (
    .clk       (clk),
    .reset_n_i (reset_n_i),
    .load      (load),
    .x         (x_i),
    .y         (y_i),
    .base      (base_i),
    .stride    (stride_i),
    .bpp8      (bpp8_i),
    .addr      (calc_addr)
  );

  // Next state and next values of the write-bus registers.
  always_comb begin
    state_d = state_q;
    addr_d  = vram.addr;
    data_d  = vram.data;
    mask_d  = vram.mask;
    case (state_q)
      ST_IDLE: begin
        if (accept && in_clip) state_d = ST_CALC;
      end
      ST_CALC: begin
        addr_d = calc_addr;
        data_d = pix_data(bpp8_q, color_q);
        mask_d = pix_mask(bpp8_q, xlo_q);
`ifdef PIXEL_COALESCE_EN
        state_d = ST_ACCUM;
`else
        state_d = ST_WRITE;
`endif
      end
      ST_WRITE: begin
        if (vram.ack) state_d = ST_IDLE;
      end
      ST_ACCUM: begin
`ifdef PIXEL_COALESCE_EN
        if (flush_i || !match) begin
          state_d = ST_WRITE;
        end else if (accept && in_clip) begin
          mask_d = vram.mask | pix_mask(bpp8_q, x_i[1:0]);
        end
`else
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= ST_IDLE;
      ready_q   <= 1'b1;
      busy_o    <= 1'b0;
      vram.wr   <= 1'b0;
      vram.addr <= '0;
      vram.data <= '0;
      vram.mask <= '0;
    end else begin
      state_q   <= state_d;
      ready_q   <= (state_d == ST_IDLE);
      busy_o    <= (state_d != ST_IDLE);
      vram.wr   <= (state_d == ST_WRITE);
      vram.addr <= addr_d;
      vram.data <= data_d;
      vram.mask <= mask_d;
    end
  end

  // Per-pixel attributes captured at accept and held for the rest of the transaction.
  always_ff @(posedge clk or negedge reset_n_i) begin
    if (!reset_n_i) begin
      bpp8_q  <= BPP4;
      color_q <= '0;
      xlo_q   <= '0;
`ifdef PIXEL_COALESCE_EN
      xw_q    <= '0;
      yw_q    <= '0;
`endif
    end else if (load) begin
      bpp8_q  <= bpp8_i;
      color_q <= color_i;
      xlo_q   <= x_i[1:0];
`ifdef PIXEL_COALESCE_EN
      xw_q    <= xw_in;
      yw_q    <= y_i;
`endif
    end
  end

endmodule

// File: tb/tb_draw_pixel_writer.sv
// Directed, table-driven bench for draw_pixel_writer (default build or PIXEL_COALESCE_EN).
module tb_draw_pixel_writer;

  localparam int unsigned CORDW = 10;
  localparam int unsigned ADDRW = 16;
`ifdef PIXEL_COALESCE_EN
  localparam int WR_LAT = 3;
`else
  localparam int WR_LAT = 2;
`endif

  typedef struct {
    logic signed [9:0] x;
    logic signed [9:0] y;
    logic              bpp8;
    logic [7:0]        color;
    logic [15:0]       base;
    logic [15:0]       stride;
    int                delay;
    logic              wr;
    logic [15:0]       addr;
    logic [15:0]       data;
    logic [3:0]        mask;
  } vec_t;

  logic                    clk = 1'b0;
  logic                    reset_n_i;
  logic                    pixel_valid_i;
  logic                    ready_o;
  logic signed [CORDW-1:0] x_i, y_i;
  logic                    flush_i;
  logic [ADDRW-1:0]        base_i, stride_i;
  logic [CORDW-1:0]        width_i, height_i;
  logic                    bpp8_i;
  logic [7:0]              color_i;
  logic                    busy_o;
  logic                    auto_ack, ack_man;

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0]  wr_masks[$];
  logic [15:0] wr_addrs[$];

  draw_pixel_writer_if #(.ADDRW(ADDRW)) vif ();
  assign vif.ack = auto_ack ? vif.wr : ack_man;

  draw_pixel_writer #(
    .CORDW (CORDW),
    .ADDRW (ADDRW)
  ) dut (
    .clk           (clk),
    .reset_n_i     (reset_n_i),
    .pixel_valid_i (pixel_valid_i),
    .ready_o       (ready_o),
    .x_i           (x_i),
    .y_i           (y_i),
    .flush_i       (flush_i),
    .base_i        (base_i),
    .stride_i      (stride_i),
    .width_i       (width_i),
    .height_i      (height_i),
    .bpp8_i        (bpp8_i),
    .color_i       (color_i),
    .vram          (vif.master),
    .busy_o        (busy_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (vif.wr && vif.ack) begin
      wr_masks.push_back(vif.mask);
      wr_addrs.push_back(vif.addr);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(input int x, input int y, input logic bpp8, input logic [7:0] c,
                               input logic [15:0] base, input logic [15:0] stride, input int delay,
                               input logic wr, input logic [15:0] addr, input logic [15:0] data,
                               input logic [3:0] mask);
    vec_t v;
    v.x = 10'(x);  v.y = 10'(y);  v.bpp8 = bpp8;  v.color = c;
    v.base = base; v.stride = stride; v.delay = delay;
    v.wr = wr;     v.addr = addr; v.data = data;  v.mask = mask;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    x_i = v.x; y_i = v.y; bpp8_i = v.bpp8; color_i = v.color;
    base_i = v.base; stride_i = v.stride;
  endtask

  task automatic apply(input vec_t v, input string tag);
    @(negedge clk);
    drive(v);
    pixel_valid_i = 1'b1;
    #1 chk({tag, ".ready_pre"}, 32'(ready_o), 32'(1));
    @(posedge clk);
    #1 pixel_valid_i = 1'b0;
    if (!v.wr) begin
      repeat (3) begin
        chk({tag, ".no_wr"}, 32'(vif.wr), 32'(0));
        chk({tag, ".ready"}, 32'(ready_o), 32'(1));
        chk({tag, ".busy"},  32'(busy_o), 32'(0));
        @(posedge clk); #1;
      end
    end else begin
      chk({tag, ".busy"},  32'(busy_o), 32'(1));
      chk({tag, ".ready"}, 32'(ready_o), 32'(0));
      for (int i = 1; i < WR_LAT; i++) begin
        chk({tag, ".wr_early"}, 32'(vif.wr), 32'(0));
        @(posedge clk); #1;
      end
      chk({tag, ".wr"},   32'(vif.wr), 32'(1));
      chk({tag, ".addr"}, 32'(vif.addr), 32'(v.addr));
      chk({tag, ".data"}, 32'(vif.data), 32'(v.data));
      chk({tag, ".mask"}, 32'(vif.mask), 32'(v.mask));
      ack_man = (v.delay == 0);
      for (int d = 1; d <= v.delay; d++) begin
        @(posedge clk); #1;
        chk({tag, ".wr_hold"},   32'(vif.wr), 32'(1));
        chk({tag, ".addr_hold"}, 32'(vif.addr), 32'(v.addr));
        chk({tag, ".mask_hold"}, 32'(vif.mask), 32'(v.mask));
        chk({tag, ".ready_hold"}, 32'(ready_o), 32'(0));
        if (d == v.delay) ack_man = 1'b1;
      end
      @(posedge clk); #1;
      ack_man = 1'b0;
      chk({tag, ".wr_drop"},    32'(vif.wr), 32'(0));
      chk({tag, ".ready_post"}, 32'(ready_o), 32'(1));
      chk({tag, ".busy_post"},  32'(busy_o), 32'(0));
    end
  endtask

  vec_t        vecs[10];
  logic [3:0]  exp_masks[4];
  int          exp_n;

  initial begin
    vecs[0] = mkv(  3,   2, 1'b0, 8'h05, 16'h1000, 16'd80,  0, 1'b1, 16'h10A0, 16'h5555, 4'b0001);
    vecs[1] = mkv(  5,   0, 1'b1, 8'hA7, 16'h1000, 16'd80,  4, 1'b1, 16'h1002, 16'hA7A7, 4'b0011);
    vecs[2] = mkv( -1,   0, 1'b0, 8'h01, 16'h1000, 16'd80,  0, 1'b0, 16'h0000, 16'h0000, 4'b0000);
    vecs[3] = mkv(320,   5, 1'b0, 8'h01, 16'h1000, 16'd80,  0, 1'b0, 16'h0000, 16'h0000, 4'b0000);
    vecs[4] = mkv(  0, 240, 1'b0, 8'h01, 16'h1000, 16'd80,  0, 1'b0, 16'h0000, 16'h0000, 4'b0000);
    vecs[5] = mkv(  0,   1, 1'b0, 8'h0C, 16'hFFF0, 16'h20,  0, 1'b1, 16'h0010, 16'hCCCC, 4'b1000);
    vecs[6] = mkv(  4,   3, 1'b1, 8'h3C, 16'h2000, 16'd160, 2, 1'b1, 16'h21E2, 16'h3C3C, 4'b1100);
    vecs[7] = mkv(  6,   1, 1'b0, 8'h9F, 16'h0000, 16'd80,  0, 1'b1, 16'h0051, 16'hFFFF, 4'b0010);
    vecs[8] = mkv(319, 239, 1'b0, 8'h02, 16'h0000, 16'd80,  1, 1'b1, 16'h4AFF, 16'h2222, 4'b0001);
    vecs[9] = mkv(  0,  -1, 1'b0, 8'h02, 16'h0000, 16'd80,  0, 1'b0, 16'h0000, 16'h0000, 4'b0000);

    reset_n_i = 1'b0; pixel_valid_i = 1'b0; flush_i = 1'b0;
    auto_ack = 1'b0; ack_man = 1'b0;
    width_i = 10'd320; height_i = 10'd240;
    drive(vecs[0]);

    repeat (3) @(posedge clk);
    #1;
    chk("reset.wr",   32'(vif.wr), 32'(0));
    chk("reset.busy", 32'(busy_o), 32'(0));
    chk("reset.addr", 32'(vif.addr), 32'(0));
    chk("reset.data", 32'(vif.data), 32'(0));
    chk("reset.mask", 32'(vif.mask), 32'(0));
    @(negedge clk) reset_n_i = 1'b1;
    @(posedge clk); #1;
    chk("reset.ready_after", 32'(ready_o), 32'(1));

    // Ack while idle must not start anything.
    ack_man = 1'b1;
    @(posedge clk); #1;
    ack_man = 1'b0;
    chk("idle_ack.wr",   32'(vif.wr), 32'(0));
    chk("idle_ack.busy", 32'(busy_o), 32'(0));

    // flush stays high through single-pixel vectors: a no-op in IDLE, closes ACCUM when coalescing.
    flush_i = 1'b1;
    for (int i = 0; i < 10; i++) apply(vecs[i], $sformatf("vec%0d", i));

    // Reset in the middle of a held write.
    @(negedge clk);
    drive(vecs[7]);
    pixel_valid_i = 1'b1;
    @(posedge clk);
    #1 pixel_valid_i = 1'b0;
    repeat (WR_LAT - 1) @(posedge clk);
    #1 chk("rst_mid.wr_before", 32'(vif.wr), 32'(1));
    reset_n_i = 1'b0;
    #1;
    chk("rst_mid.wr",   32'(vif.wr), 32'(0));
    chk("rst_mid.busy", 32'(busy_o), 32'(0));
    chk("rst_mid.addr", 32'(vif.addr), 32'(0));
    @(negedge clk) reset_n_i = 1'b1;
    apply(vecs[0], "after_rst");

    // Horizontal 4bpp run on one word, then flush.
    flush_i = 1'b0;
    auto_ack = 1'b1;
    wr_masks.delete();
    wr_addrs.delete();
    for (int i = 0; i < 4; i++) begin
      int tries = 0;
      @(negedge clk);
      drive(mkv(i, 7, 1'b0, 8'h06, 16'h0100, 16'd40, 0, 1'b1, 16'h0, 16'h0, 4'h0));
      pixel_valid_i = 1'b1;
      #1;
      while (!ready_o && tries < 20) begin
        @(negedge clk); #1;
        tries++;
      end
      chk($sformatf("run.px%0d_accepted", i), 32'(tries < 20), 32'(1));
      @(posedge clk);
    end
    @(negedge clk);
    pixel_valid_i = 1'b0;
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    repeat (10) @(posedge clk);
    #1;
`ifdef PIXEL_COALESCE_EN
    exp_n = 1;
    exp_masks[0] = 4'b1111;
`else
    exp_n = 4;
    exp_masks[0] = 4'b1000; exp_masks[1] = 4'b0100;
    exp_masks[2] = 4'b0010; exp_masks[3] = 4'b0001;
`endif
    chk("run.write_count", 32'(wr_masks.size()), 32'(exp_n));
    for (int i = 0; i < exp_n; i++) begin
      chk($sformatf("run.mask%0d", i), (i < wr_masks.size()) ? 32'(wr_masks[i]) : 32'hDEAD,
          32'(exp_masks[i]));
      chk($sformatf("run.addr%0d", i), (i < wr_addrs.size()) ? 32'(wr_addrs[i]) : 32'hDEAD,
          32'h0218);
    end
    chk("run.idle_busy", 32'(busy_o), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
